// File: rtl/bram2stream_burst_master_if.sv
// Stream output and memory read port bundle for bram2stream_burst_master.
// master = the burst engine, slave = the stream sink / memory side.
interface bram2stream_burst_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0]   S_AXIS_TDATA;
  logic [DATA_W/8-1:0] S_AXIS_TSTRB;
  logic                S_AXIS_TLAST;
  logic                S_AXIS_TVALID;
  logic                S_AXIS_TREADY;
  logic [ADDR_W-1:0]   src_addr;
  logic                src_enable;
  logic [DATA_W-1:0]   src_data;
  logic                src_ready;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
    input  S_AXIS_TREADY,
    output src_addr, src_enable,
    input  src_data, src_ready
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
    output S_AXIS_TREADY,
    input  src_addr, src_enable,
    output src_data, src_ready
  );
endinterface

// File: rtl/bram2stream_burst_master.sv
// Streams cfg_length words from a fixed-latency memory onto an AXI-Stream port, TLAST every cfg_pkt_len beats.
// First beat RD_LATENCY+2 cycles after start; reads are credit-limited so the output FIFO never overflows under TREADY stalls.
module bram2stream_burst_master #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int SRC_ADDR_WIDTH       = 12,
  parameter int RD_LATENCY           = 2,
  parameter int LEN_WIDTH            = 16,
  parameter int FIFO_DEPTH           = RD_LATENCY + 2
) (
  input  logic                      S_AXIS_ACLK,
  input  logic                      S_AXIS_ARESET,
  input  logic                      start,
  input  logic [SRC_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]      cfg_length,
  input  logic [LEN_WIDTH-1:0]      cfg_pkt_len,
  output logic                      busy,
  output logic                      done,
  bram2stream_burst_master_if.master bus
);
  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic [LEN_WIDTH-1:0]      len_q, pkt_q, rd_left, wr_idx, pkt_idx;
  logic [SRC_ADDR_WIDTH-1:0] addr_q;
  logic [RD_LATENCY-1:0]     vld_sr;
  logic [DW:0]               fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic                      issue, wr_en, rd_en, wr_last, tvalid, pkt_end;
  int                        inflight;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in the latency pipe count against FIFO space so a full stall can always be absorbed.
  always_comb begin
    inflight = $countones(vld_sr) + int'(count);
  end

  assign issue   = (state == RUN) && bus.src_ready && (inflight < FIFO_DEPTH);
  assign wr_en   = vld_sr[RD_LATENCY-1];
  assign tvalid  = (count != '0);
  assign rd_en   = tvalid && bus.S_AXIS_TREADY;
  assign pkt_end = (pkt_q != '0) && (pkt_idx == pkt_q - 1'b1);
  assign wr_last = pkt_end || (wr_idx == len_q - 1'b1);

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state   <= IDLE;
      len_q   <= '0;
      pkt_q   <= '0;
      rd_left <= '0;
      wr_idx  <= '0;
      pkt_idx <= '0;
      addr_q  <= '0;
      vld_sr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LATENCY'(issue);
      count  <= count + CW'(wr_en) - CW'(rd_en);
      if (wr_en) begin
        wr_ptr  <= nxt(wr_ptr);
        wr_idx  <= wr_idx + 1'b1;
        pkt_idx <= pkt_end ? '0 : pkt_idx + 1'b1;
      end
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      if (issue) begin
        addr_q  <= addr_q + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          len_q   <= cfg_length;
          pkt_q   <= cfg_pkt_len;
          addr_q  <= cfg_base_addr;
          rd_left <= cfg_length;
          wr_idx  <= '0;
          pkt_idx <= '0;
          state   <= (cfg_length != '0) ? RUN : DONE;
        end
        RUN:     if (issue && rd_left == LEN_WIDTH'(1)) state <= DRAIN;
        DRAIN:   if (count == '0 && vld_sr == '0) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (wr_en) fifo_mem[wr_ptr] <= {bus.src_data, wr_last};
  end

  assign bus.S_AXIS_TVALID = tvalid;
  assign bus.S_AXIS_TDATA  = tvalid ? fifo_mem[rd_ptr][DW:1] : '0;
  assign bus.S_AXIS_TLAST  = tvalid ? fifo_mem[rd_ptr][0] : 1'b0;
  assign bus.S_AXIS_TSTRB  = '1;
  assign bus.src_addr      = addr_q;
  assign bus.src_enable    = issue;
  assign busy              = (state == RUN) || (state == DRAIN);
  assign done              = (state == DONE);
endmodule

// File: tb/tb_bram2stream_burst_master.sv
// Scoreboard bench: three DUTs (RD_LATENCY 1, 2, 4) run the same randomized transfer sequence in parallel.
module tb_bram2stream_burst_master;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fin    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lat
    localparam int L     = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int DEPTH = L + 2;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [LW-1:0] cfg_len = '0;
    logic [LW-1:0] cfg_pkt = '0;
    logic          busy, done;

    bram2stream_burst_master_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();

    bram2stream_burst_master #(
      .C_S_AXIS_TDATA_WIDTH(DW), .SRC_ADDR_WIDTH(AW), .RD_LATENCY(L), .LEN_WIDTH(LW)
    ) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start),
      .cfg_base_addr(cfg_base), .cfg_length(cfg_len), .cfg_pkt_len(cfg_pkt),
      .busy(busy), .done(done), .bus(sif)
    );

    function automatic string nm(input string s);
      return $sformatf("L%0d_%s", L, s);
    endfunction

    // Memory: word a holds 0xA0000000+a, returned exactly L cycles after the strobe, junk otherwise.
    logic [AW-1:0] ap [L];
    logic          vp [L];
    always @(posedge clk) begin
      ap[0] <= sif.src_addr;
      vp[0] <= sif.src_enable;
      for (int i = 1; i < L; i++) begin
        ap[i] <= ap[i-1];
        vp[i] <= vp[i-1];
      end
    end
    assign sif.src_data = vp[L-1] ? (32'hA000_0000 + 32'(ap[L-1])) : 32'hDEAD_BEEF;

    int rdy_mode = 0;
    bit sr_toggle = 1'b0;
    bit pat [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    initial begin
      int pidx = 0;
      sif.S_AXIS_TREADY = 1'b1;
      sif.src_ready     = 1'b1;
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0: sif.S_AXIS_TREADY = 1'b1;
          1: sif.S_AXIS_TREADY = 1'($urandom_range(0, 1));
          default: begin
            sif.S_AXIS_TREADY = pat[pidx];
            pidx = (pidx + 1) % 8;
          end
        endcase
        sif.src_ready = sr_toggle ? !sif.src_ready : 1'b1;
      end
    end

    beat_t         exp_q [$];
    logic [AW-1:0] exp_addr = '0;
    int issued = 0, beats = 0, done_cnt = 0, en_cnt = 0;
    int first_en = -1, first_vld = -1, start_cyc = 0, done_cyc = 0, last_beat_cyc = 0;
    bit    stall = 1'b0;
    beat_t held;

    always @(negedge clk) begin
      if (!rst) begin
        if (sif.src_enable) begin
          issued++;
          en_cnt++;
          if (first_en < 0) first_en = cyc;
          check(nm("rd_when_ready"), 64'(sif.src_ready), 64'd1);
          check(nm("rd_addr"), 64'(sif.src_addr), 64'(exp_addr));
          check(nm("credit"), 64'(issued - beats <= DEPTH), 64'd1);
          exp_addr++;
        end
        if (sif.S_AXIS_TVALID) begin
          if (first_vld < 0) first_vld = cyc;
          if (stall) check(nm("stall_hold"), 64'({sif.S_AXIS_TDATA, sif.S_AXIS_TLAST}), 64'(held));
          if (sif.S_AXIS_TREADY) begin
            check(nm("beat_expected"), 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
              check(nm("beat"), 64'({sif.S_AXIS_TDATA, sif.S_AXIS_TLAST}), 64'(exp_q.pop_front()));
            beats++;
            last_beat_cyc = cyc;
          end
        end else if (stall) begin
          check(nm("stall_valid_kept"), 64'(sif.S_AXIS_TVALID), 64'd1);
        end
        stall = sif.S_AXIS_TVALID && !sif.S_AXIS_TREADY;
        held  = {sif.S_AXIS_TDATA, sif.S_AXIS_TLAST};
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end

    // Expected stream straight from the packetisation rules.
    task automatic go(input int base, input int len, input int pkt);
      @(posedge clk); #1;
      for (int i = 0; i < len; i++) begin
        beat_t b;
        b.d = 32'hA000_0000 + 32'((base + i) % (1 << AW));
        b.l = ((pkt != 0) && ((i % pkt) == pkt - 1)) || (i == len - 1);
        exp_q.push_back(b);
      end
      cfg_base  = AW'(base);
      cfg_len   = LW'(len);
      cfg_pkt   = LW'(pkt);
      exp_addr  = AW'(base);
      issued    = 0;
      beats     = 0;
      en_cnt    = 0;
      first_en  = -1;
      first_vld = -1;
      start_cyc = cyc;
      start     = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      cfg_base = AW'($urandom);
      cfg_len  = LW'($urandom);
      cfg_pkt  = LW'($urandom);
    endtask

    task automatic wait_done(input string tag, input int d0);
      int t = 0;
      while (done_cnt == d0 && t < 20000) begin
        @(posedge clk);
        t++;
      end
      check(nm({tag, "_done_seen"}), 64'(t < 20000), 64'd1);
      repeat (3) @(posedge clk);
      check(nm({tag, "_done_once"}), 64'(done_cnt - d0), 64'd1);
      check(nm({tag, "_drained"}), 64'(exp_q.size()), 64'd0);
      check(nm({tag, "_idle"}), 64'(busy), 64'd0);
    endtask

    initial begin
      int d0, t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(nm("reset_outputs"),
            64'({sif.S_AXIS_TSTRB, sif.S_AXIS_TVALID, sif.S_AXIS_TLAST, sif.src_enable, busy, done,
                 sif.src_addr, sif.S_AXIS_TDATA}),
            64'({4'hF, 47'd0}));
      @(posedge clk); #1;
      rst = 1'b0;

      d0 = done_cnt;
      go(0, 1024, 0);
      wait_done("burst", d0);
      check(nm("first_en_cycle"), 64'(first_en), 64'(start_cyc + 1));
      check(nm("first_vld_cycle"), 64'(first_vld), 64'(start_cyc + 2 + L));
      check(nm("burst_b2b"), 64'(last_beat_cyc - first_vld), 64'd1023);

      d0 = done_cnt;
      go(10'h3FE, 4, 3);
      wait_done("wrap", d0);

      rdy_mode = 1;
      d0 = done_cnt;
      go($urandom_range(0, 1023), 256, $urandom_range(0, 9));
      wait_done("rand_ready", d0);

      rdy_mode = 2;
      d0 = done_cnt;
      go($urandom_range(0, 1023), 256, 7);
      wait_done("pattern_ready", d0);

      rdy_mode  = 1;
      sr_toggle = 1'b1;
      d0 = done_cnt;
      go($urandom_range(0, 1023), 200, 16);
      wait_done("src_toggle", d0);
      sr_toggle = 1'b0;
      rdy_mode  = 0;

      d0 = done_cnt;
      go(5, 0, 0);
      repeat (4) @(posedge clk);
      check(nm("zero_done_cycle"), 64'(done_cyc), 64'(start_cyc + 1));
      check(nm("zero_done_count"), 64'(done_cnt - d0), 64'd1);
      check(nm("zero_no_reads"), 64'(en_cnt), 64'd0);
      check(nm("zero_no_valid"), 64'(first_vld), -64'sd1);

      d0 = done_cnt;
      go(100, 64, 5);
      repeat (8) @(posedge clk);
      #1;
      check(nm("busy_mid"), 64'(busy), 64'd1);
      cfg_base = 10'h200;
      cfg_len  = 16'd3;
      cfg_pkt  = 16'd1;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("start_while_busy", d0);

      d0 = done_cnt;
      go(200, 100, 0);
      t = 0;
      while (beats < 10 && t < 5000) begin
        @(posedge clk);
        t++;
      end
      check(nm("rst_beats_seen"), 64'(t < 5000), 64'd1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      stall  = 1'b0;
      issued = 0;
      beats  = 0;
      @(negedge clk);
      check(nm("rst_abort_outputs"),
            64'({sif.S_AXIS_TSTRB, sif.S_AXIS_TVALID, sif.S_AXIS_TLAST, sif.src_enable, busy, done,
                 sif.src_addr, sif.S_AXIS_TDATA}),
            64'({4'hF, 47'd0}));
      repeat (20) @(posedge clk);
      check(nm("rst_no_done"), 64'(done_cnt - d0), 64'd0);
      check(nm("rst_no_beats"), 64'(beats), 64'd0);

      d0 = done_cnt;
      go(300, 50, 8);
      wait_done("after_reset", d0);

      n_fin++;
    end
  end

  initial begin
    int t = 0;
    while (n_fin < 3 && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (n_fin < 3) begin
      n_checks++;
      $display("FAIL timeout: finished %0d of 3 latency blocks", n_fin);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bram2stream_burst_master.md
BRAM2STREAM_BURST_MASTER -- requirements
Module: bram2stream_burst_master

Interface
REQ-001 The block SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, giving the stream and memory data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter SRC_ADDR_WIDTH, default 12, giving the memory word-address width.
REQ-003 The block SHALL have parameter RD_LATENCY, default 2, legal 1..4, giving the memory read latency in cycles from src_enable to src_data.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16, giving the width of the transfer-length and packet-length fields.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default RD_LATENCY+2, giving the output buffer depth in words (minimum RD_LATENCY+1).
REQ-006 S_AXIS_ACLK  in  1  single clock; all logic on its rising edge.
REQ-007 S_AXIS_ARESET  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request; samples cfg_* while idle.
REQ-009 cfg_base_addr  in  SRC_ADDR_WIDTH  first word address.
REQ-010 cfg_length  in  LEN_WIDTH  total words to transfer.
REQ-011 cfg_pkt_len  in  LEN_WIDTH  words per packet (TLAST period); 0 means one packet of cfg_length.
REQ-012 S_AXIS_TREADY  in  1  downstream ready.
REQ-013 S_AXIS_TDATA  out  C_S_AXIS_TDATA_WIDTH  stream data.
REQ-014 S_AXIS_TSTRB  out  C_S_AXIS_TDATA_WIDTH/8  byte strobes, constant all ones.
REQ-015 S_AXIS_TLAST  out  1  last beat of packet.
REQ-016 S_AXIS_TVALID  out  1  stream valid.
REQ-017 src_addr  out  SRC_ADDR_WIDTH  memory read address.
REQ-018 src_enable  out  1  memory read strobe.
REQ-019 src_data  in  C_S_AXIS_TDATA_WIDTH  memory read data, valid RD_LATENCY cycles after src_enable.
REQ-020 src_ready  in  1  memory accepts a read this cycle.
REQ-021 busy  out  1  transfer in progress.
REQ-022 done  out  1  one-cycle pulse at transfer completion.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with cfg_length!=0; IDLE->DONE on start with cfg_length==0; RUN->DRAIN after the final read is issued; DRAIN->DONE when FIFO empty and no read outstanding; DONE->IDLE unconditionally after one cycle.
REQ-024 start SHALL be ignored in every state except IDLE; cfg_* SHALL be latched only on an accepted start.
REQ-025 src_enable SHALL assert only in RUN, when src_ready=1 and (outstanding reads + FIFO occupancy) < FIFO_DEPTH; a read is issued exactly when src_enable=1.
REQ-026 src_addr SHALL start at cfg_base_addr and increment by 1 per issued read, wrapping modulo 2^SRC_ADDR_WIDTH.
REQ-027 An internal RD_LATENCY-deep valid shift register SHALL track issued reads; src_data SHALL be written into the FIFO on the edge ending cycle N+RD_LATENCY for a read issued in cycle N.
REQ-028 The credit rule SHALL guarantee no FIFO overflow for any TREADY pattern; data SHALL never be dropped or duplicated.
REQ-029 S_AXIS_TVALID SHALL equal FIFO not-empty; a beat SHALL transfer when TVALID and TREADY are both 1; TDATA/TLAST SHALL remain stable while TVALID=1 and TREADY=0.
REQ-030 With start accepted at edge T and TREADY=1, first src_enable SHALL be in cycle T+1 and first TVALID in cycle T+2+RD_LATENCY; steady-state throughput SHALL be one word per cycle.
REQ-031 TLAST SHALL assert on every beat whose index within the packet is cfg_pkt_len-1, and always on the final beat of the transfer (a short final packet is permitted).
REQ-032 Simultaneous FIFO write and read SHALL keep occupancy unchanged, including when full or empty.
REQ-033 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE; done SHALL be 1 only in DONE.

Reset
REQ-034 While S_AXIS_ARESET=1 at an edge, the FSM SHALL go to IDLE, FIFO, counters and valid pipeline SHALL clear, and S_AXIS_TVALID, S_AXIS_TLAST, src_enable, busy, done SHALL be 0, src_addr and S_AXIS_TDATA 0.
REQ-035 Reset mid-transfer SHALL abort with no further beats, no done pulse, and memory data returning after reset SHALL be discarded.

Verification
REQ-036 RD_LATENCY=2, memory[i]=0xA0000000+i, base=0, length=1024, pkt_len=0, TREADY=1 -> 1024 beats 0xA0000000..0xA00003FF back-to-back, TLAST only on beat 1023, one done pulse.
REQ-037 base=0x3FE (SRC_ADDR_WIDTH=10), length=4, pkt_len=3 -> data 0x3FE,0x3FF,0x000,0x001 (+0xA0000000), TLAST on beats 3 and 4.
REQ-038 TREADY random 50% and pattern 1,1,0,1,0,0,1,1 repeating, length=256 -> exact in-order sequence, no loss or duplication, TDATA stable under stall, FIFO never exceeds FIFO_DEPTH.
REQ-039 length=0 -> done pulse one cycle after start, TVALID and src_enable never assert; start during busy -> ignored, cfg unchanged.
REQ-040 RD_LATENCY=1 and 4, src_ready toggling every cycle -> reads issued only when src_ready=1, output sequence correct.
REQ-041 Reset asserted for one cycle after 10 beats of a 100-word transfer -> outputs zero next cycle, no done pulse, new start then transfers correctly from its base.
